// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and jump/cmov
// condition codes. Used by the pipeline control unit and the datapath stages.
package y86_pkg;

    typedef logic [3:0] icode_t;
    typedef logic [2:0] stat_t;

    localparam icode_t I_HALT   = 4'h0;
    localparam icode_t I_NOP    = 4'h1;
    localparam icode_t I_RRMOVQ = 4'h2;
    localparam icode_t I_IRMOVQ = 4'h3;
    localparam icode_t I_RMMOVQ = 4'h4;
    localparam icode_t I_MRMOVQ = 4'h5;
    localparam icode_t I_OPQ    = 4'h6;
    localparam icode_t I_JXX    = 4'h7;
    localparam icode_t I_CALL   = 4'h8;
    localparam icode_t I_RET    = 4'h9;
    localparam icode_t I_PUSHQ  = 4'hA;
    localparam icode_t I_POPQ   = 4'hB;

    localparam stat_t S_AOK = 3'd1;
    localparam stat_t S_HLT = 3'd2;
    localparam stat_t S_ADR = 3'd3;
    localparam stat_t S_INS = 3'd4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Register-id value meaning "no register"
    localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/y86_pipe_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the control unit (slave).
interface y86_pipe_ctrl_if #(parameter int CNT_W = 32);
    import y86_pkg::*;

    icode_t     D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    icode_t     E_icode;
    logic [3:0] E_ifun;
    logic [3:0] E_dstM;
    logic       e_zf;
    logic       e_sf;
    logic       e_of;
    icode_t     M_icode;
    stat_t      m_stat;
    icode_t     W_icode;
    stat_t      W_stat;

    logic       e_cnd;
    logic       zf;
    logic       sf;
    logic       of;
    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       halted;
    stat_t      stat_out;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_dstM,
               e_zf, e_sf, e_of, M_icode, m_stat, W_icode, W_stat,
        input  e_cnd, zf, sf, of, F_stall, D_stall, D_bubble, E_bubble,
               M_bubble, W_stall, halted, stat_out, cycle_cnt, retired_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_dstM,
               e_zf, e_sf, e_of, M_icode, m_stat, W_icode, W_stat,
        output e_cnd, zf, sf, of, F_stall, D_stall, D_bubble, E_bubble,
               M_bubble, W_stall, halted, stat_out, cycle_cnt, retired_cnt
    );

endinterface

// File: rtl/y86_cc_unit.sv
// Condition-code register and branch/cmov condition evaluation for execute.
module y86_cc_unit
    import y86_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  icode_t     E_icode_i,
    input  logic [3:0] E_ifun_i,
    input  logic       e_zf_i,
    input  logic       e_sf_i,
    input  logic       e_of_i,
    input  stat_t      m_stat_i,
    input  stat_t      W_stat_i,
    input  logic       halted_i,
    output logic       e_cnd_o,
    output logic       zf_o,
    output logic       sf_o,
    output logic       of_o
);

    logic zf_q, sf_q, of_q;
    logic zf_d, sf_d, of_d;
    logic set_cc;
    logic lt;
    logic cnd_raw;

    // An OPQ updates flags only if no older instruction is faulting and the core still runs
    always_comb begin
        set_cc = (E_icode_i == I_OPQ) && (m_stat_i == S_AOK) &&
                 (W_stat_i == S_AOK) && !halted_i;
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (set_cc) begin
            zf_d = e_zf_i;
            sf_d = e_sf_i;
            of_d = e_of_i;
        end
    end

    // Flag register; reset state is "last result was zero"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    // Evaluate ifun against registered flags; non-conditional instructions see "true"
    always_comb begin
        lt      = sf_q ^ of_q;
        cnd_raw = 1'b0;
        case (E_ifun_i)
            C_YES:   cnd_raw = 1'b1;
            C_LE:    cnd_raw = lt | zf_q;
            C_L:     cnd_raw = lt;
            C_E:     cnd_raw = zf_q;
            C_NE:    cnd_raw = ~zf_q;
            C_GE:    cnd_raw = ~lt;
            C_G:     cnd_raw = ~lt & ~zf_q;
            default: cnd_raw = 1'b0;
        endcase
        if ((E_icode_i == I_JXX) || (E_icode_i == I_RRMOVQ)) begin
            e_cnd_o = cnd_raw;
        end else begin
            e_cnd_o = 1'b1;
        end
    end

    assign zf_o = zf_q;
    assign sf_o = sf_q;
    assign of_o = of_q;

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Pipeline control: hazard stall/bubble generation, exception/halt drain FSM,
// and cycle / retired-instruction counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | normal operation
// ST_DRAIN  | faulting instruction seen in M, waiting for it to reach W
// ST_HALTED | final status latched, pipeline frozen until reset
module y86_pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input logic            clk,
    input logic            rst_n,
    y86_pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_e;

    ctrl_state_e      state_q, state_d;
    stat_t            stat_q, stat_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic halted;
    logic e_cnd;
    logic cc_zf, cc_sf, cc_of;
    logic load_use, ret_hz, mispred;

    assign halted = (state_q == ST_HALTED);

    y86_cc_unit u_cc (
        .clk       (clk),
        .rst_n     (rst_n),
        .E_icode_i (bus.E_icode),
        .E_ifun_i  (bus.E_ifun),
        .e_zf_i    (bus.e_zf),
        .e_sf_i    (bus.e_sf),
        .e_of_i    (bus.e_of),
        .m_stat_i  (bus.m_stat),
        .W_stat_i  (bus.W_stat),
        .halted_i  (halted),
        .e_cnd_o   (e_cnd),
        .zf_o      (cc_zf),
        .sf_o      (cc_sf),
        .of_o      (cc_of)
    );

    // Hazard detection and per-stage stall/bubble controls (same-cycle)
    always_comb begin
        load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                   (bus.E_dstM != REG_NONE) &&
                   ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        ret_hz   = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                   (bus.M_icode == I_RET);
        mispred  = (bus.E_icode == I_JXX) && !e_cnd;

        bus.F_stall  = 1'b1;
        bus.D_stall  = 1'b1;
        bus.D_bubble = 1'b0;
        bus.E_bubble = 1'b0;
        bus.M_bubble = 1'b0;
        bus.W_stall  = 1'b1;
        if (!halted) begin
            bus.F_stall  = load_use | ret_hz;
            bus.D_stall  = load_use;
            // D register gives bubble priority over stall when both are set
            bus.D_bubble = mispred | (ret_hz & ~load_use);
            bus.E_bubble = mispred | load_use;
            bus.M_bubble = (bus.m_stat != S_AOK) | (bus.W_stat != S_AOK);
            bus.W_stall  = (bus.W_stat != S_AOK);
        end
    end

    // Status FSM next-state; final status captured on the transition into HALTED
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        case (state_q)
            ST_RUN: begin
                if (bus.W_stat != S_AOK) begin
                    state_d = ST_HALTED;
                    stat_d  = bus.W_stat;
                end else if (bus.m_stat != S_AOK) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.W_stat != S_AOK) begin
                    state_d = ST_HALTED;
                    stat_d  = bus.W_stat;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Performance counters, frozen once halted
    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (!halted) begin
            cyc_d = cyc_q + CNT_W'(1);
            if ((bus.W_stat == S_AOK) && (bus.W_icode != I_NOP)) begin
                ret_d = ret_q + CNT_W'(1);
            end
        end
    end

    // State, status and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            stat_q  <= S_AOK;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
        end
    end

    assign bus.e_cnd       = e_cnd;
    assign bus.zf          = cc_zf;
    assign bus.sf          = cc_sf;
    assign bus.of          = cc_of;
    assign bus.halted      = halted;
    assign bus.stat_out    = stat_q;
    assign bus.cycle_cnt   = cyc_q;
    assign bus.retired_cnt = ret_q;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Scoreboard bench for y86_pipe_ctrl: a stimulus process predicts each cycle's
// outputs from a behavioural model and queues them; a monitor compares them.
module tb_y86_pipe_ctrl;
    import y86_pkg::*;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    y86_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    y86_pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic             e_cnd;
        logic [2:0]       flags;   // {zf, sf, of}
        logic [5:0]       ctl;     // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
        logic             halted;
        logic [2:0]       stat;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state
    bit [2:0]         m_cc;        // {zf, sf, of}
    bit               m_stopped;
    logic [2:0]       m_final;
    logic [CNT_W-1:0] m_cyc;
    logic [CNT_W-1:0] m_ret;

    function automatic bit cond_holds(logic [3:0] ifun, bit z, bit s, bit o);
        bit less = s ^ o;
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return less || z;
            4'd2:    return less;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !less;
            4'd6:    return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit lu, rh, mp, ce;
        ce = (bus.E_icode == I_JXX || bus.E_icode == I_RRMOVQ) ?
             cond_holds(bus.E_ifun, m_cc[2], m_cc[1], m_cc[0]) : 1'b1;
        lu = (bus.E_icode == I_MRMOVQ || bus.E_icode == I_POPQ) && bus.E_dstM != 4'hF &&
             (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
        rh = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
        mp = (bus.E_icode == I_JXX) && !ce;
        e.e_cnd = ce;
        e.flags = m_cc;
        if (m_stopped) begin
            e.ctl = 6'b110001;
        end else begin
            e.ctl = {lu || rh, lu, mp || (rh && !lu), mp || lu,
                     bus.m_stat != S_AOK || bus.W_stat != S_AOK, bus.W_stat != S_AOK};
        end
        e.halted = m_stopped;
        e.stat   = m_final;
        e.cyc    = m_cyc;
        e.ret    = m_ret;
        return e;
    endfunction

    task automatic model_reset();
        m_cc      = 3'b100;
        m_stopped = 1'b0;
        m_final   = S_AOK;
        m_cyc     = '0;
        m_ret     = '0;
    endtask

    // What a clock edge does to the architectural view of the controller
    task automatic model_clock();
        if (!m_stopped) begin
            if (bus.E_icode == I_OPQ && bus.m_stat == S_AOK && bus.W_stat == S_AOK)
                m_cc = {bus.e_zf, bus.e_sf, bus.e_of};
            m_cyc = m_cyc + 1;
            if (bus.W_stat == S_AOK && bus.W_icode != I_NOP)
                m_ret = m_ret + 1;
            if (bus.W_stat != S_AOK) begin
                m_stopped = 1'b1;
                m_final   = bus.W_stat;
            end
        end
    endtask

    // Called at posedge+1 with inputs already applied
    task automatic step();
        sb_q.push_back(predict());
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    task automatic set_idle();
        bus.D_icode = I_NOP;
        bus.d_srcA  = 4'hF;
        bus.d_srcB  = 4'hF;
        bus.E_icode = I_NOP;
        bus.E_ifun  = 4'h0;
        bus.E_dstM  = 4'hF;
        bus.e_zf    = 1'b0;
        bus.e_sf    = 1'b0;
        bus.e_of    = 1'b0;
        bus.M_icode = I_NOP;
        bus.m_stat  = S_AOK;
        bus.W_icode = I_NOP;
        bus.W_stat  = S_AOK;
    endtask

    function automatic logic [3:0] pick_reg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    function automatic logic [2:0] pick_stat(int odds);
        if ($urandom_range(0, odds - 1) == 0) return 3'($urandom_range(2, 4));
        return S_AOK;
    endfunction

    task automatic rand_inputs();
        bus.D_icode = 4'($urandom_range(0, 11));
        bus.d_srcA  = pick_reg();
        bus.d_srcB  = pick_reg();
        bus.E_icode = 4'($urandom_range(0, 11));
        bus.E_ifun  = 4'($urandom_range(0, 15));
        bus.E_dstM  = pick_reg();
        bus.e_zf    = 1'($urandom_range(0, 1));
        bus.e_sf    = 1'($urandom_range(0, 1));
        bus.e_of    = 1'($urandom_range(0, 1));
        bus.M_icode = 4'($urandom_range(0, 11));
        bus.m_stat  = pick_stat(30);
        bus.W_icode = 4'($urandom_range(0, 11));
        bus.W_stat  = pick_stat(60);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the queued prediction against what the DUT presents
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("e_cnd",       32'(bus.e_cnd),    32'(e.e_cnd));
                chk("cc_flags",    32'({bus.zf, bus.sf, bus.of}), 32'(e.flags));
                chk("F_stall",     32'(bus.F_stall),  32'(e.ctl[5]));
                chk("D_stall",     32'(bus.D_stall),  32'(e.ctl[4]));
                chk("D_bubble",    32'(bus.D_bubble), 32'(e.ctl[3]));
                chk("E_bubble",    32'(bus.E_bubble), 32'(e.ctl[2]));
                chk("M_bubble",    32'(bus.M_bubble), 32'(e.ctl[1]));
                chk("W_stall",     32'(bus.W_stall),  32'(e.ctl[0]));
                chk("halted",      32'(bus.halted),   32'(e.halted));
                chk("stat_out",    32'(bus.stat_out), 32'(e.stat));
                chk("cycle_cnt",   bus.cycle_cnt,     e.cyc);
                chk("retired_cnt", bus.retired_cnt,   e.ret);
            end
        end
    end

    icode_t retire_codes[5] = '{I_IRMOVQ, I_RMMOVQ, I_CALL, I_PUSHQ, I_OPQ};

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        @(posedge clk);
        #1;

        // Reset with flag inputs toggling; JXX/E condition on reset flags
        bus.E_icode = I_JXX;
        bus.E_ifun  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            bus.e_zf = 1'(i);
            bus.e_sf = ~1'(i);
            bus.e_of = ~1'(i);
            step();
        end
        rst_n = 1'b1;
        step();

        // OPQ sets flags; following JXX evaluates them
        set_idle();
        bus.E_icode = I_OPQ;
        bus.e_sf    = 1'b1;
        step();
        bus.E_icode = I_JXX;
        bus.E_ifun  = 4'd2;
        step();
        bus.E_ifun  = 4'd5;
        step();

        // Load/use hazard and its disappearance with E_dstM = none
        set_idle();
        bus.E_icode = I_MRMOVQ;
        bus.E_dstM  = 4'd3;
        bus.d_srcB  = 4'd3;
        step();
        bus.E_dstM  = 4'hF;
        step();

        // Ret hazard alone, then together with load/use
        set_idle();
        bus.D_icode = I_RET;
        step();
        bus.E_icode = I_POPQ;
        bus.E_dstM  = 4'd2;
        bus.d_srcA  = 4'd2;
        step();

        // Retire five real instructions and two NOPs, then reset asynchronously
        set_idle();
        foreach (retire_codes[i]) begin
            bus.W_icode = retire_codes[i];
            step();
        end
        bus.W_icode = I_NOP;
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;

        // Address fault in M with OPQ in E, then in W, then frozen
        set_idle();
        bus.E_icode = I_OPQ;
        bus.e_of    = 1'b1;
        bus.m_stat  = S_ADR;
        step();
        set_idle();
        bus.W_stat  = S_ADR;
        step();
        set_idle();
        bus.E_icode = I_OPQ;
        bus.W_icode = I_HALT;
        repeat (3) step();
        bus.W_stat  = S_HLT;
        step();

        // Randomised traffic with periodic resets
        rst_n = 1'b0;
        model_reset();
        set_idle();
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            if ((m_stopped && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        if (bus.W_stat == S_INS) checks = checks + 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/y86_pipe_ctrl.md
# y86_pipe_ctrl

Central pipeline control unit for the pipelined Y86-64 core. It owns the condition-code register and evaluates branch/cmov conditions for the execute stage. It generates per-stage stall/bubble controls for load/use, ret and mispredict hazards, and sequences exception/halt drain through a small status FSM. It also keeps cycle and retired-instruction counters.

## Interface
Parameters:
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- D_icode  in  4  icode in decode register.
- d_srcA, d_srcB  in  4 each  decode source registers (4'hF = none).
- E_icode, E_ifun  in  4 each  execute register icode/ifun.
- E_dstM  in  4  execute-stage memory destination.
- e_zf, e_sf, e_of  in  1 each  flags computed by the execute ALU this cycle.
- M_icode  in  4  memory register icode.
- m_stat  in  3  status out of memory stage.
- W_icode  in  4  writeback register icode.
- W_stat  in  3  writeback register status.
- e_cnd  out  1  condition result for E_ifun against the CC register.
- zf, sf, of  out  1 each  CC register contents.
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline register controls.
- halted  out  1  core stopped.
- stat_out  out  3  latched final status (AOK until halt).
- cycle_cnt, retired_cnt  out  CNT_W each  performance counters.

## Operation
- Codes: icode HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. Stat AOK 1, HLT 2, ADR 3, INS 4.
- e_cnd (combinational): ifun 0 → 1; 1 LE → (sf^of)|zf; 2 L → sf^of; 3 E → zf; 4 NE → ~zf; 5 GE → ~(sf^of); 6 G → ~(sf^of)&~zf; 7–F → 0. Valid only when E_icode is JXX or RRMOVQ. Otherwise e_cnd = 1, so dstE passes unchanged.
- set_cc = (E_icode==OPQ) & (m_stat==AOK) & (W_stat==AOK) & ~halted. When set, CC takes {e_zf,e_sf,e_of} at the next edge.
- load_use = E_icode∈{MRMOVQ,POPQ} & E_dstM≠F & E_dstM∈{d_srcA,d_srcB}.
- ret_hz = RET∈{D_icode,E_icode,M_icode}.
- mispred = (E_icode==JXX) & ~e_cnd.
- F_stall = load_use | ret_hz.
- D_stall = load_use.
- D_bubble = mispred | (ret_hz & ~load_use).
- E_bubble = mispred | load_use.
- M_bubble = (m_stat≠AOK) | (W_stat≠AOK).
- W_stall = W_stat≠AOK.
- FSM states:
  - RUN → DRAIN when m_stat≠AOK.
  - RUN → HALTED directly when W_stat≠AOK.
  - DRAIN → HALTED when W_stat≠AOK.
  - HALTED is absorbing until reset.
- In HALTED: F_stall=D_stall=W_stall=1, all bubbles 0, halted=1, stat_out holds the W_stat captured on entry, and CC is frozen.
- Counters:
  - cycle_cnt increments every cycle outside HALTED.
  - retired_cnt increments when W_stat==AOK & W_icode≠NOP & ~halted.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset (async assert, sync release):
  - zf=1, sf=0, of=0.
  - FSM=RUN, halted=0, stat_out=AOK (3'd1).
  - counters 0.
  - All stall/bubble outputs follow their equations from reset-time inputs.
- Stall/bubble and e_cnd are same-cycle combinational. There are no registers on these paths.
- CC update latency is 1 cycle: an OPQ in E sets flags visible to a JXX/cmov in E the following cycle.
- Simultaneous load_use and mispred: mispred wins for D (D_bubble=1, D_stall=1 both asserted; the D register treats bubble as priority). E_bubble=1.
- Simultaneous load_use and ret_hz: stall D, bubble E, no D_bubble.
- Exception in M concurrent with OPQ in E: CC not written.
- Reset asserted mid-DRAIN returns to RUN immediately. The counters clear.

## Structure
- Shared package y86_pkg: icode constants, stat constants, ifun condition constants, 3-bit stat_t and 4-bit icode_t typedefs. The datapath stages also use this package.
- Sub-module y86_cc_unit: CC register, set_cc gating and condition evaluation. Outputs e_cnd and flags.
- Hazard equations, FSM and counters stay in the top module.

## Test plan
- Reset with zf/sf/of inputs toggling → zf=1, sf=0, of=0, cycle_cnt=0. E_icode=JXX, ifun=3 gives e_cnd=1.
- OPQ in E with e_zf=0, e_sf=1, e_of=0, then JXX ifun=2 (L) next cycle → e_cnd=1. With ifun=5 (GE): e_cnd=0, mispred, so D_bubble=E_bubble=1.
- E_icode=MRMOVQ, E_dstM=3, d_srcB=3 → F_stall=D_stall=E_bubble=1, D_bubble=0. E_dstM=F → all 0.
- D_icode=RET with no load_use → F_stall=1, D_bubble=1. Add load_use simultaneously → D_bubble=0, D_stall=1.
- m_stat=ADR (3) with OPQ in E → CC unchanged, M_bubble=1, FSM DRAIN. Next cycle W_stat=3 → halted=1, stat_out=3, and cycle_cnt frozen thereafter.
- Retire 5 non-NOP AOK instructions plus 2 NOPs in W → retired_cnt=5. Assert rst_n=0 mid-run → retired_cnt=0 asynchronously.
